// File: rtl/mod_mult.sv
// rtl/mod_mult.sv - iterative Blakley modular multiplier, (A*B) mod M or A^2 mod M
// Optional MOD_MULT_SKIP_ZEROS_EN: start iterating at the most-significant 1 of A.
module mod_mult #(
    parameter int WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             ready_in,
    input  logic             square_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] modulus_in,
    output logic [WIDTH-1:0] result_out,
    output logic             busy_out,
    output logic             valid_out,
    output logic             error_out
);

    localparam int IW = $clog2(WIDTH);
    localparam int RW = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ITER  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] m_reg;
    logic [RW-1:0]    r_reg;
    logic [IW-1:0]    idx;
    // Early finish (error, or A==0 when skipping) is reported one cycle after CHECK.
    logic             early_done;
    logic             early_err;

    logic [RW-1:0] m_ext;
    logic [RW-1:0] t_sum;
    logic [RW-1:0] t_once;
    logic [RW-1:0] t_red;
    logic          check_err;

    always_comb begin
        m_ext     = {2'b00, m_reg};
        // R < M keeps 2R + B below 3M, so two conditional subtractions suffice.
        t_sum     = {r_reg[RW-2:0], 1'b0} + (a_reg[idx] ? {2'b00, b_reg} : '0);
        t_once    = (t_sum >= m_ext) ? (t_sum - m_ext) : t_sum;
        t_red     = (t_once >= m_ext) ? (t_once - m_ext) : t_once;
        check_err = (m_reg == '0) || (b_reg >= m_reg);
    end

`ifdef MOD_MULT_SKIP_ZEROS_EN
    logic [IW-1:0] msb_idx;

    always_comb begin
        msb_idx = '0;
        for (int j = 0; j < WIDTH; j++) begin
            if (a_reg[j]) begin
                msb_idx = IW'(j);
            end
        end
    end
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            m_reg      <= '0;
            r_reg      <= '0;
            idx        <= '0;
            early_done <= 1'b0;
            early_err  <= 1'b0;
            result_out <= '0;
            busy_out   <= 1'b0;
            valid_out  <= 1'b0;
            error_out  <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            error_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (ready_in) begin
                        a_reg    <= a_in;
                        b_reg    <= square_in ? a_in : b_in;
                        m_reg    <= modulus_in;
                        busy_out <= 1'b1;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    r_reg      <= '0;
                    early_err  <= check_err;
                    early_done <= check_err;
`ifdef MOD_MULT_SKIP_ZEROS_EN
                    idx <= msb_idx;
                    if (a_reg == '0) begin
                        early_done <= 1'b1;
                    end
`else
                    idx <= IW'(WIDTH - 1);
`endif
                    state <= ITER;
                end
                ITER: begin
                    if (early_done) begin
                        result_out <= '0;
                        error_out  <= early_err;
                        valid_out  <= 1'b1;
                        busy_out   <= 1'b0;
                        early_done <= 1'b0;
                        early_err  <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        r_reg <= t_red;
                        if (idx == '0) begin
                            result_out <= t_red[WIDTH-1:0];
                            valid_out  <= 1'b1;
                            busy_out   <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            idx <= idx - IW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_mult.sv
// tb/tb_mod_mult.sv - self-checking bench for mod_mult against an arithmetic reference
module tb_mod_mult;

    localparam int WIDTH = 16;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b1;
    logic             ready_in = 1'b0;
    logic             square_in = 1'b0;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic [WIDTH-1:0] modulus_in = '0;
    logic [WIDTH-1:0] result_out;
    logic             busy_out;
    logic             valid_out;
    logic             error_out;

    int checks = 0;
    int errors = 0;

    mod_mult #(.WIDTH(WIDTH)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .ready_in   (ready_in),
        .square_in  (square_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .modulus_in (modulus_in),
        .result_out (result_out),
        .busy_out   (busy_out),
        .valid_out  (valid_out),
        .error_out  (error_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [15:0] a, input logic [15:0] b,
                                               input logic [15:0] m, input logic sq);
        logic [63:0] bb;
        bb = sq ? 64'(a) : 64'(b);
        if (m == 0 || bb >= 64'(m)) return 64'd0;
        return (64'(a) * bb) % 64'(m);
    endfunction

    function automatic logic ref_error(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] m, input logic sq);
        return (m == 0) || ((sq ? a : b) >= m);
    endfunction

    // One request; optionally scrambles inputs and ready_in while busy.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] m,
                          input logic sq, input bit disturb, input string tag);
        logic [63:0] exp_r;
        logic        exp_e;
        int          n;
        bit          seen;
        exp_r = ref_result(a, b, m, sq);
        exp_e = ref_error(a, b, m, sq);
        @(negedge clk_in);
        a_in = a; b_in = b; modulus_in = m; square_in = sq; ready_in = 1'b1;
        @(posedge clk_in);
        #1 ready_in = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk_in);
            #1 n++;
            if (n == 1) check({tag, "_busy"}, busy_out, 1'b1);
            if (disturb) begin
                a_in = 16'($urandom); b_in = 16'($urandom); modulus_in = 16'($urandom);
                square_in = 1'($urandom); ready_in = 1'($urandom);
            end
            if (valid_out) seen = 1'b1;
        end
        ready_in = 1'b0;
        check({tag, "_valid"}, seen, 1'b1);
        if (seen) begin
            check({tag, "_latency"}, n, exp_e ? 2 : WIDTH + 1);
            check({tag, "_result"}, result_out, exp_r);
            check({tag, "_error"}, error_out, exp_e);
            check({tag, "_busy_low"}, busy_out, 1'b0);
            @(posedge clk_in);
            #1;
            check({tag, "_valid_drop"}, {valid_out, error_out}, 2'b00);
        end
    endtask

    initial begin
        logic [15:0] ra, rb, rm;
        logic        rs;
        int          pulses;
        int          b2b_bad;

        repeat (2) @(posedge clk_in);
        #1;
        check("reset_outputs", {result_out, busy_out, valid_out, error_out}, '0);
        rst_in = 1'b0;

        run_op(16'd7, 16'd9, 16'd13, 1'b0, 1'b0, "basic");
        run_op(16'd5, 16'h1234, 16'd7, 1'b1, 1'b0, "square");
        run_op(16'hFFFE, 16'hFFFE, 16'hFFFF, 1'b0, 1'b0, "max_mod");
        run_op(16'hFFFF, 16'd1, 16'h8000, 1'b0, 1'b0, "a_over_m");
        run_op(16'd9, 16'd0, 16'd1, 1'b0, 1'b0, "m_one");
        run_op(16'd3, 16'd4, 16'd0, 1'b0, 1'b0, "err_m0");
        run_op(16'd3, 16'd20, 16'd13, 1'b0, 1'b0, "err_b_ge_m");
        run_op(16'd13, 16'd0, 16'd13, 1'b1, 1'b0, "err_square");
        run_op(16'd7, 16'd9, 16'd13, 1'b0, 1'b1, "disturb");

        for (int k = 0; k < 16; k++) begin
            rm = 16'($urandom_range(1, 65535));
            rs = 1'($urandom);
            ra = 16'($urandom);
            rb = 16'($urandom) % rm;
            if (rs) ra = ra % rm;
            run_op(ra, rb, rm, rs, bit'(k % 4 == 3), $sformatf("rand%0d", k));
        end

        // Back-to-back: ready held for three acceptances (edges 0, 18, 36).
        @(negedge clk_in);
        a_in = 16'h1234; b_in = 16'h0567; modulus_in = 16'h9ABC; square_in = 1'b0;
        ready_in = 1'b1;
        @(posedge clk_in);
        pulses = 0;
        b2b_bad = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk_in);
            #1;
            if (n == 36) ready_in = 1'b0;
            if (valid_out) begin
                pulses++;
                if (64'(result_out) !== ref_result(16'h1234, 16'h0567, 16'h9ABC, 1'b0)) b2b_bad++;
            end
        end
        check("b2b_pulses", pulses, 3);
        check("b2b_results_bad", b2b_bad, 0);

        // Reset during the fifth iteration.
        @(negedge clk_in);
        a_in = 16'hBEEF; b_in = 16'd100; modulus_in = 16'd1000; square_in = 1'b0; ready_in = 1'b1;
        @(posedge clk_in);
        #1 ready_in = 1'b0;
        repeat (6) @(posedge clk_in);
        #1 rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("abort_outputs", {result_out, busy_out, valid_out, error_out}, '0);
        rst_in = 1'b0;
        pulses = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk_in);
            #1;
            if (valid_out) pulses++;
        end
        check("abort_no_valid", pulses, 0);
        run_op(16'd2, 16'd3, 16'd5, 1'b0, 1'b0, "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
